ekg_peak_detector: RTL and testbench

//  Sink for the 24-bit ECG sample stream produced by the gen_ekg_* generators.

---
 rtl/ekg_peak_detector.sv | 126 ++++++++++++
 tb/tb_ekg_peak_detector.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ekg_peak_detector.sv
// ekg_peak_detector: R-peak detector for a signed ECG sample stream.
// A sample above THRESHOLD opens a local-maximum search. The first sample that
// falls below the running maximum declares the peak. A refractory window
// follows, and the R-R interval is reported in valid-sample units.
module ekg_peak_detector #(
  parameter int                       DATA_W     = 24,
  parameter logic signed [DATA_W-1:0] THRESHOLD  = DATA_W'(1048576),
  parameter int                       REFRACTORY = 50,
  parameter int                       RR_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  output logic                     peak,
  output logic signed [DATA_W-1:0] peak_value,
  output logic [RR_W-1:0]          rr_interval,
  output logic                     rr_valid,
  output logic [15:0]              beat_count
);

  localparam int REF_W = (REFRACTORY > 1) ? $clog2(REFRACTORY) : 1;

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_TRACK   = 2'd1,
    S_REFRACT = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic signed [DATA_W-1:0]   r_max;
  logic [RR_W-1:0]            r_cap;
  logic [RR_W-1:0]            r_cnt;
  logic [REF_W-1:0]           r_ref_cnt;
  logic                       r_first_beat;
  logic                       w_declare;
  logic                       w_load_max;
  logic [RR_W-1:0]            w_cnt_inc;

  // Saturating increment: the interval counter sticks at all-ones, never wraps.
  function automatic logic [RR_W-1:0] sat_inc(input logic [RR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_cnt_inc = sat_inc(r_cnt);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_SEARCH;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-sample strobes. Only valid samples move the FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_declare   = 1'b0;
    w_load_max  = 1'b0;
    if (data_valid) begin
      case (r_state)
        S_SEARCH: begin
          if (data_in > THRESHOLD) begin
            w_state_nxt = S_TRACK;
            w_load_max  = 1'b1;
          end
        end
        S_TRACK: begin
          if (data_in >= r_max) begin
            w_load_max = 1'b1;
          end else begin
            w_declare   = 1'b1;
            w_state_nxt = S_REFRACT;
          end
        end
        S_REFRACT: begin
          if (r_ref_cnt == '0) w_state_nxt = S_SEARCH;
        end
        default: w_state_nxt = S_SEARCH;
      endcase
    end
  end

  // Sample counter, maximum capture, refractory countdown and peak outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max        <= '0;
      r_cap        <= '0;
      r_cnt        <= '0;
      r_ref_cnt    <= '0;
      r_first_beat <= 1'b1;
      peak         <= 1'b0;
      peak_value   <= '0;
      rr_interval  <= '0;
      rr_valid     <= 1'b0;
      beat_count   <= '0;
    end else begin
      peak     <= 1'b0;
      rr_valid <= 1'b0;
      if (data_valid) begin
        // A declare only happens on the sample right after the last >= max
        // sample, so the declaring sample is always one sample past the peak.
        // Re-basing to 1 also stays exact when the counter had saturated.
        r_cnt <= w_declare ? RR_W'(1) : w_cnt_inc;
        if (w_load_max) begin
          r_max <= data_in;
          r_cap <= w_cnt_inc;
        end
        if (w_declare) begin
          peak       <= 1'b1;
          peak_value <= r_max;
          beat_count <= beat_count + 1'b1;
          r_ref_cnt  <= REF_W'(REFRACTORY - 1);
          if (r_first_beat) begin
            r_first_beat <= 1'b0;
          end else begin
            rr_valid    <= 1'b1;
            rr_interval <= r_cap;
          end
        end else if (r_state == S_REFRACT && r_ref_cnt != '0) begin
          r_ref_cnt <= r_ref_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ekg_peak_detector.sv
// Testbench for ekg_peak_detector: directed sample sequences. Each expected
// peak event is queued when its pulse is issued, and a monitor compares each
// event against the queue whenever the DUT pulses peak.
module tb_ekg_peak_detector;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [23:0] data_in = '0;
  logic               data_valid = 1'b0;
  logic               peak;
  logic signed [23:0] peak_value;
  logic [15:0]        rr_interval;
  logic               rr_valid;
  logic [15:0]        beat_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [23:0] pv;
    logic               rv;
    logic [15:0]        rr;
    logic [15:0]        bc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  ekg_peak_detector dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .peak       (peak),
    .peak_value (peak_value),
    .rr_interval(rr_interval),
    .rr_valid   (rr_valid),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic signed [23:0] pv, input logic rv,
                      input logic [15:0] rr, input logic [15:0] bc);
    exp_t e;
    e.pv = pv; e.rv = rv; e.rr = rr; e.bc = bc;
    q.push_back(e);
  endtask

  task automatic send(input logic signed [23:0] v, input bit toggle);
    @(posedge clk); #1;
    data_in    = v;
    data_valid = 1'b1;
    if (toggle) begin
      @(posedge clk); #1;
      data_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      data_valid = 1'b0;
    end
  endtask

  // zeros, then 2000000 / pk / 2000000 / 0; peak sample is pk.
  task automatic pulse(input int zeros, input logic signed [23:0] pk, input bit toggle);
    for (int i = 0; i < zeros; i++) send(24'sd0, toggle);
    send(24'sd2000000, toggle);
    send(pk, toggle);
    send(24'sd2000000, toggle);
    send(24'sd0, toggle);
  endtask

  // Monitor: every peak pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (peak === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_peak value %0d beat_count %0d expected no peak",
                   peak_value, beat_count);
        end else begin
          mon_e = q.pop_front();
          chk("peak_value", peak_value, mon_e.pv);
          chk("rr_valid", rr_valid, mon_e.rv);
          if (mon_e.rv) chk("rr_interval", rr_interval, mon_e.rr);
          chk("beat_count", beat_count, mon_e.bc);
        end
      end else if (rr_valid === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL rr_valid_without_peak got 1 expected 0");
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_peak", peak, 0);
    chk("rst_peak_value", peak_value, 0);
    chk("rst_rr_interval", rr_interval, 0);
    chk("rst_rr_valid", rr_valid, 0);
    chk("rst_beat_count", beat_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Build some state: one beat, then enter TRACK and reset asynchronously
    push(24'sd3000000, 1'b0, 16'd0, 16'd1);
    pulse(3, 24'sd3000000, 1'b0);
    for (int i = 0; i < 55; i++) send(24'sd0, 1'b0);
    send(24'sd2000000, 1'b0);
    send(24'sd2500000, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_rst_peak_value", peak_value, 0);
    chk("async_rst_beat_count", beat_count, 0);
    chk("async_rst_peak", peak, 0);
    chk("async_rst_rr_valid", rr_valid, 0);
    data_in = 24'sd2600000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      data_valid = ~data_valid;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    data_valid = 1'b0;
    // zeros after reset must not declare a stale tracked maximum
    for (int i = 0; i < 10; i++) send(24'sd0, 1'b1);

    // First beat after reset
    push(24'sd3000000, 1'b0, 16'd0, 16'd1);
    send(24'sd0, 1'b0);
    send(24'sd0, 1'b0);
    send(24'sd2000000, 1'b0);
    send(24'sd3000000, 1'b0);
    send(24'sd2000000, 1'b0);
    send(24'sd0, 1'b0);

    // Second beat 100 samples later, data_valid toggling
    push(24'sd3000000, 1'b1, 16'd100, 16'd2);
    pulse(96, 24'sd3000000, 1'b1);

    // Excursion at +10 inside refractory window: ignored
    for (int i = 0; i < 6; i++) send(24'sd0, 1'b0);
    send(24'sd2000000, 1'b0);
    send(24'sd3500000, 1'b0);
    send(24'sd2000000, 1'b0);
    send(24'sd0, 1'b0);
    // Excursion at +60: detected
    push(24'sd2500000, 1'b1, 16'd60, 16'd3);
    pulse(46, 24'sd2500000, 1'b0);

    // Plateau: peak on the last equal sample (+80)
    push(24'sd3000000, 1'b1, 16'd80, 16'd4);
    for (int i = 0; i < 75; i++) send(24'sd0, 1'b0);
    for (int i = 0; i < 3; i++) send(24'sd3000000, 1'b0);
    send(24'sd1000, 1'b0);
    for (int i = 0; i < 100; i++) send(-24'sd8388608, 1'b0);

    // Interval of 70000 saturates, then a 100-sample interval recovers
    push(24'sd3000000, 1'b1, 16'd65535, 16'd5);
    pulse(69897, 24'sd3000000, 1'b0);
    push(24'sd2800000, 1'b1, 16'd100, 16'd6);
    pulse(96, 24'sd2800000, 1'b0);

    idle(5);
    chk("pending_expected_peaks", q.size(), 0);
    chk("final_beat_count", beat_count, 6);
    chk("final_rr_interval_held", rr_interval, 100);
    chk("final_peak_value_held", peak_value, 2800000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
